// File: rtl/alu_pkg.sv
// Shared constants and types for the multi-cycle ALU.
package alu_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned OPSEL_W  = 2;
    localparam int unsigned FLAGS_W  = 4;

    // Opcode encodings
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_AND = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_OR  = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_CMP = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_SHL = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_SHR = 3'd7;

    // Flag bit positions within Read_Flag
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // OperandSelect encodings
    localparam logic [OPSEL_W-1:0] OPSEL_A_B   = 2'b00;
    localparam logic [OPSEL_W-1:0] OPSEL_T1_B  = 2'b01;
    localparam logic [OPSEL_W-1:0] OPSEL_A_T1  = 2'b10;
    localparam logic [OPSEL_W-1:0] OPSEL_T1_T1 = 2'b11;

    // FSM state type and encodings
    typedef logic [1:0] aluState_t;
    localparam aluState_t S_IDLE  = 2'd0;
    localparam aluState_t S_SHIFT = 2'd1;
    localparam aluState_t S_DONE  = 2'd2;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle arithmetic/logic result and flag generation.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [OPCODE_W-1:0] opCode,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    result,
    output logic [FLAGS_W-1:0]  flags
);

    logic             isSub;
    logic [WIDTH-1:0] bArith;
    logic [WIDTH:0]   sumExt;
    logic             carry;
    logic             ovf;

    // Adder with inverted B and carry-in for SUB/CMP; shifts here are the count-0 pass-through
    always_comb begin
        isSub  = (opCode == OP_SUB) || (opCode == OP_CMP);
        bArith = isSub ? ~b : b;
        sumExt = {1'b0, a} + {1'b0, bArith} + (WIDTH+1)'(isSub);
        result = a;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (opCode)
            OP_ADD, OP_SUB, OP_CMP: begin
                result = sumExt[WIDTH-1:0];
                carry  = sumExt[WIDTH];
                ovf    = (a[WIDTH-1] == bArith[WIDTH-1]) && (sumExt[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = a;
        endcase
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_multicycle_core.sv
// The combinational datapath core is implemented in alu_comb_core.sv.

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arith/logic, bit-serial shifts, registered T1 and flags.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic                ClockInput,
    input  logic                ResetN,
    input  logic                Enable,
    input  logic [OPCODE_W-1:0] ExtOpCode,
    input  logic [OPSEL_W-1:0]  OperandSelect,
    input  logic                UpdateResult,
    input  logic                UpdateFlag,
    input  logic [WIDTH-1:0]    Bus_A,
    input  logic [WIDTH-1:0]    Bus_B,
    output logic [WIDTH-1:0]    Read_T1,
    output logic [FLAGS_W-1:0]  Read_Flag,
    output logic                Busy,
    output logic                Done
);

    aluState_t            state;
    aluState_t            nextState;
    logic [WIDTH-1:0]     opA;
    logic [WIDTH-1:0]     opB;
    logic [WIDTH-1:0]     coreResult;
    logic [FLAGS_W-1:0]   coreFlags;
    logic                 accept;
    logic                 isShiftOp;
    logic [CW-1:0]        shAmt;
    logic                 startShift;
    logic                 lastShift;
    logic [WIDTH-1:0]     shReg;
    logic [CW-1:0]        shCnt;
    logic                 shLeft;
    logic                 shUpdRes;
    logic                 shUpdFlag;
    logic [WIDTH-1:0]     shNext;
    logic                 shCarryOut;
    logic [FLAGS_W-1:0]   shFlags;

    // Operand selection; T1 taken from its current (pre-update) register value
    always_comb begin
        opA = Bus_A;
        opB = Bus_B;
        case (OperandSelect)
            OPSEL_T1_B:  opA = Read_T1;
            OPSEL_A_T1:  opB = Read_T1;
            OPSEL_T1_T1: begin
                opA = Read_T1;
                opB = Read_T1;
            end
            default: ;
        endcase
    end

    alu_comb_core #(.WIDTH(WIDTH)) uCore (
        .opCode (ExtOpCode),
        .a      (opA),
        .b      (opB),
        .result (coreResult),
        .flags  (coreFlags)
    );

    // Accept decode and next step of the serial shifter
    always_comb begin
        accept     = Enable && !Busy;
        isShiftOp  = (ExtOpCode == OP_SHL) || (ExtOpCode == OP_SHR);
        shAmt      = Bus_B[CW-1:0];
        startShift = accept && isShiftOp && (shAmt != '0);
        lastShift  = (shCnt == CW'(1));
        if (shLeft) begin
            shNext     = {shReg[WIDTH-2:0], 1'b0};
            shCarryOut = shReg[WIDTH-1];
        end else begin
            shNext     = {1'b0, shReg[WIDTH-1:1]};
            shCarryOut = shReg[0];
        end
        shFlags         = '0;
        shFlags[FLAG_Z] = (shNext == '0);
        shFlags[FLAG_N] = shNext[WIDTH-1];
        shFlags[FLAG_C] = shCarryOut;
    end

    // Next-state logic; DONE can chain straight into a new operation
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) nextState = startShift ? S_SHIFT : S_DONE;
                else        nextState = S_IDLE;
            end
            S_SHIFT: if (lastShift) nextState = S_DONE;
            default: nextState = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ClockInput) begin
        if (!ResetN) state <= S_IDLE;
        else         state <= nextState;
    end

    // Datapath: result/flag writes, shift iteration, Busy/Done
    always_ff @(posedge ClockInput) begin
        if (!ResetN) begin
            Read_T1   <= '0;
            Read_Flag <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            shReg     <= '0;
            shCnt     <= '0;
            shLeft    <= 1'b0;
            shUpdRes  <= 1'b0;
            shUpdFlag <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == S_SHIFT) begin
                shReg <= shNext;
                shCnt <= shCnt - CW'(1);
                if (lastShift) begin
                    Busy <= 1'b0;
                    Done <= 1'b1;
                    if (shUpdRes)  Read_T1   <= shNext;
                    if (shUpdFlag) Read_Flag <= shFlags;
                end
            end else if (accept) begin
                shLeft    <= (ExtOpCode == OP_SHL);
                shUpdRes  <= UpdateResult;
                shUpdFlag <= UpdateFlag;
                if (startShift) begin
                    shReg <= opA;
                    shCnt <= shAmt;
                    Busy  <= 1'b1;
                end else begin
                    Done <= 1'b1;
                    if (UpdateResult && (ExtOpCode != OP_CMP)) Read_T1 <= coreResult;
                    if (UpdateFlag) Read_Flag <= coreFlags;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=16).
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 16;

    logic             ClockInput;
    logic             ResetN;
    logic             Enable;
    logic [2:0]       ExtOpCode;
    logic [1:0]       OperandSelect;
    logic             UpdateResult;
    logic             UpdateFlag;
    logic [WIDTH-1:0] Bus_A;
    logic [WIDTH-1:0] Bus_B;
    logic [WIDTH-1:0] Read_T1;
    logic [3:0]       Read_Flag;
    logic             Busy;
    logic             Done;

    int testsRun    = 0;
    int testsFailed = 0;

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .ClockInput    (ClockInput),
        .ResetN        (ResetN),
        .Enable        (Enable),
        .ExtOpCode     (ExtOpCode),
        .OperandSelect (OperandSelect),
        .UpdateResult  (UpdateResult),
        .UpdateFlag    (UpdateFlag),
        .Bus_A         (Bus_A),
        .Bus_B         (Bus_B),
        .Read_T1       (Read_T1),
        .Read_Flag     (Read_Flag),
        .Busy          (Busy),
        .Done          (Done)
    );

    initial ClockInput = 1'b0;
    always #5 ClockInput = ~ClockInput;

    task automatic step;
        @(posedge ClockInput);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] sel, input logic ur,
                         input logic uf, input logic [15:0] a, input logic [15:0] b);
        Enable        = 1'b1;
        ExtOpCode     = op;
        OperandSelect = sel;
        UpdateResult  = ur;
        UpdateFlag    = uf;
        Bus_A         = a;
        Bus_B         = b;
    endtask

    task automatic test_reset;
        ResetN = 1'b0;
        drive(OP_ADD, OPSEL_A_B, 1'b1, 1'b1, 16'h0001, 16'h0001);
        step;
        step;
        testsRun++; if (Read_T1 !== 16'h0000) begin testsFailed++; $display("FAIL reset_t1 got=%h exp=%h", Read_T1, 16'h0000); end
        testsRun++; if (Read_Flag !== 4'b0000) begin testsFailed++; $display("FAIL reset_flag got=%b exp=%b", Read_Flag, 4'b0000); end
        testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        testsRun++; if (Done !== 1'b0) begin testsFailed++; $display("FAIL reset_done got=%b exp=0", Done); end
        ResetN = 1'b1;
        step;
        Enable = 1'b0;
        testsRun++; if (Done !== 1'b1) begin testsFailed++; $display("FAIL first_accept_done got=%b exp=1", Done); end
        testsRun++; if (Read_T1 !== 16'h0002) begin testsFailed++; $display("FAIL first_accept_t1 got=%h exp=%h", Read_T1, 16'h0002); end
        step;
        testsRun++; if (Done !== 1'b0) begin testsFailed++; $display("FAIL first_accept_done_clear got=%b exp=0", Done); end
    endtask

    task automatic test_add_overflow;
        drive(OP_ADD, OPSEL_A_B, 1'b1, 1'b1, 16'h7FFF, 16'h0001);
        step;
        Enable = 1'b0;
        testsRun++; if (Done !== 1'b1) begin testsFailed++; $display("FAIL add_done got=%b exp=1", Done); end
        testsRun++; if (Read_T1 !== 16'h8000) begin testsFailed++; $display("FAIL add_t1 got=%h exp=%h", Read_T1, 16'h8000); end
        testsRun++; if (Read_Flag !== 4'b0101) begin testsFailed++; $display("FAIL add_flag got=%b exp=%b", Read_Flag, 4'b0101); end
        testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("FAIL add_busy got=%b exp=0", Busy); end
        step;
        testsRun++; if (Done !== 1'b0) begin testsFailed++; $display("FAIL add_done_clear got=%b exp=0", Done); end
    endtask

    task automatic test_cmp;
        drive(OP_ADD, OPSEL_A_B, 1'b1, 1'b1, 16'h1234, 16'h0000);
        step;
        Enable = 1'b0;
        testsRun++; if (Read_Flag !== 4'b0000) begin testsFailed++; $display("FAIL cmp_preset_flag got=%b exp=%b", Read_Flag, 4'b0000); end
        step;
        drive(OP_CMP, OPSEL_A_B, 1'b1, 1'b1, 16'h0005, 16'h0005);
        step;
        Enable = 1'b0;
        testsRun++; if (Read_T1 !== 16'h1234) begin testsFailed++; $display("FAIL cmp_t1 got=%h exp=%h", Read_T1, 16'h1234); end
        testsRun++; if (Read_Flag !== 4'b1010) begin testsFailed++; $display("FAIL cmp_flag got=%b exp=%b", Read_Flag, 4'b1010); end
        testsRun++; if (Done !== 1'b1) begin testsFailed++; $display("FAIL cmp_done got=%b exp=1", Done); end
        step;
    endtask

    task automatic test_shl_busy;
        drive(OP_SHL, OPSEL_A_B, 1'b1, 1'b1, 16'h8001, 16'h0003);
        step;
        Enable = 1'b0;
        testsRun++; if (Busy !== 1'b1 || Done !== 1'b0) begin testsFailed++; $display("FAIL shl_k busy=%b done=%b exp busy=1 done=0", Busy, Done); end
        drive(OP_ADD, OPSEL_A_B, 1'b1, 1'b1, 16'h0001, 16'h0001);
        step;
        Enable = 1'b0;
        testsRun++; if (Busy !== 1'b1 || Done !== 1'b0) begin testsFailed++; $display("FAIL shl_k1 busy=%b done=%b exp busy=1 done=0", Busy, Done); end
        testsRun++; if (Read_T1 !== 16'h1234) begin testsFailed++; $display("FAIL shl_ignored_t1 got=%h exp=%h", Read_T1, 16'h1234); end
        step;
        testsRun++; if (Busy !== 1'b1 || Done !== 1'b0) begin testsFailed++; $display("FAIL shl_k2 busy=%b done=%b exp busy=1 done=0", Busy, Done); end
        step;
        testsRun++; if (Busy !== 1'b0 || Done !== 1'b1) begin testsFailed++; $display("FAIL shl_k3 busy=%b done=%b exp busy=0 done=1", Busy, Done); end
        testsRun++; if (Read_T1 !== 16'h0008) begin testsFailed++; $display("FAIL shl_t1 got=%h exp=%h", Read_T1, 16'h0008); end
        testsRun++; if (Read_Flag !== 4'b0000) begin testsFailed++; $display("FAIL shl_flag got=%b exp=%b", Read_Flag, 4'b0000); end
        step;
        testsRun++; if (Done !== 1'b0 || Read_T1 !== 16'h0008) begin testsFailed++; $display("FAIL shl_after done=%b t1=%h exp done=0 t1=0008", Done, Read_T1); end
    endtask

    task automatic test_shr;
        drive(OP_SHR, OPSEL_A_B, 1'b1, 1'b1, 16'h0003, 16'h0000);
        step;
        Enable = 1'b0;
        testsRun++; if (Busy !== 1'b0 || Done !== 1'b1) begin testsFailed++; $display("FAIL shr0_ctrl busy=%b done=%b exp busy=0 done=1", Busy, Done); end
        testsRun++; if (Read_T1 !== 16'h0003) begin testsFailed++; $display("FAIL shr0_t1 got=%h exp=%h", Read_T1, 16'h0003); end
        testsRun++; if (Read_Flag !== 4'b0000) begin testsFailed++; $display("FAIL shr0_flag got=%b exp=%b", Read_Flag, 4'b0000); end
        step;
        drive(OP_SHR, OPSEL_A_B, 1'b1, 1'b1, 16'h0003, 16'h0001);
        step;
        Enable = 1'b0;
        testsRun++; if (Busy !== 1'b1 || Done !== 1'b0) begin testsFailed++; $display("FAIL shr1_k busy=%b done=%b exp busy=1 done=0", Busy, Done); end
        step;
        testsRun++; if (Busy !== 1'b0 || Done !== 1'b1) begin testsFailed++; $display("FAIL shr1_k1 busy=%b done=%b exp busy=0 done=1", Busy, Done); end
        testsRun++; if (Read_T1 !== 16'h0001) begin testsFailed++; $display("FAIL shr1_t1 got=%h exp=%h", Read_T1, 16'h0001); end
        testsRun++; if (Read_Flag !== 4'b0010) begin testsFailed++; $display("FAIL shr1_flag got=%b exp=%b", Read_Flag, 4'b0010); end
        step;
    endtask

    task automatic test_logic;
        drive(OP_XOR, OPSEL_A_B, 1'b1, 1'b1, 16'hFFFF, 16'h0F0F);
        step;
        Enable = 1'b0;
        testsRun++; if (Read_T1 !== 16'hF0F0) begin testsFailed++; $display("FAIL xor_t1 got=%h exp=%h", Read_T1, 16'hF0F0); end
        testsRun++; if (Read_Flag !== 4'b0100) begin testsFailed++; $display("FAIL xor_flag got=%b exp=%b", Read_Flag, 4'b0100); end
        step;
        drive(OP_OR, OPSEL_A_B, 1'b0, 1'b1, 16'h0001, 16'h0002);
        step;
        Enable = 1'b0;
        testsRun++; if (Read_T1 !== 16'hF0F0) begin testsFailed++; $display("FAIL or_noupd_t1 got=%h exp=%h", Read_T1, 16'hF0F0); end
        testsRun++; if (Read_Flag !== 4'b0000) begin testsFailed++; $display("FAIL or_flag got=%b exp=%b", Read_Flag, 4'b0000); end
        testsRun++; if (Done !== 1'b1) begin testsFailed++; $display("FAIL or_done got=%b exp=1", Done); end
        step;
        drive(OP_ADD, OPSEL_T1_T1, 1'b1, 1'b1, 16'h0000, 16'h0000);
        step;
        Enable = 1'b0;
        testsRun++; if (Read_T1 !== 16'hE1E0) begin testsFailed++; $display("FAIL add_t1t1 got=%h exp=%h", Read_T1, 16'hE1E0); end
        testsRun++; if (Read_Flag !== 4'b0110) begin testsFailed++; $display("FAIL add_t1t1_flag got=%b exp=%b", Read_Flag, 4'b0110); end
        step;
    endtask

    task automatic test_reset_mid_shift;
        drive(OP_SHL, OPSEL_A_B, 1'b1, 1'b1, 16'h00FF, 16'h0008);
        step;
        Enable = 1'b0;
        testsRun++; if (Busy !== 1'b1) begin testsFailed++; $display("FAIL rms_start busy=%b exp=1", Busy); end
        for (int i = 0; i < 4; i++) begin
            step;
            testsRun++; if (Busy !== 1'b1 || Done !== 1'b0) begin testsFailed++; $display("FAIL rms_shift%0d busy=%b done=%b exp busy=1 done=0", i, Busy, Done); end
        end
        ResetN = 1'b0;
        step;
        testsRun++; if (Read_T1 !== 16'h0000) begin testsFailed++; $display("FAIL rms_t1 got=%h exp=%h", Read_T1, 16'h0000); end
        testsRun++; if (Read_Flag !== 4'b0000) begin testsFailed++; $display("FAIL rms_flag got=%b exp=%b", Read_Flag, 4'b0000); end
        testsRun++; if (Busy !== 1'b0 || Done !== 1'b0) begin testsFailed++; $display("FAIL rms_ctrl busy=%b done=%b exp busy=0 done=0", Busy, Done); end
        ResetN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step;
            testsRun++; if (Done !== 1'b0 || Busy !== 1'b0 || Read_T1 !== 16'h0000) begin testsFailed++; $display("FAIL rms_after%0d done=%b busy=%b t1=%h exp 0 0 0000", i, Done, Busy, Read_T1); end
        end
    endtask

    task automatic test_back_to_back;
        drive(OP_SUB, OPSEL_A_B, 1'b1, 1'b1, 16'h0010, 16'h0000);
        step;
        testsRun++; if (Done !== 1'b1 || Read_T1 !== 16'h0010) begin testsFailed++; $display("FAIL b2b_first done=%b t1=%h exp done=1 t1=0010", Done, Read_T1); end
        testsRun++; if (Read_Flag !== 4'b0010) begin testsFailed++; $display("FAIL b2b_first_flag got=%b exp=%b", Read_Flag, 4'b0010); end
        drive(OP_ADD, OPSEL_T1_B, 1'b1, 1'b0, 16'hDEAD, 16'h0020);
        step;
        Enable = 1'b0;
        testsRun++; if (Done !== 1'b1 || Busy !== 1'b0) begin testsFailed++; $display("FAIL b2b_ctrl done=%b busy=%b exp done=1 busy=0", Done, Busy); end
        testsRun++; if (Read_T1 !== 16'h0030) begin testsFailed++; $display("FAIL b2b_t1 got=%h exp=%h", Read_T1, 16'h0030); end
        testsRun++; if (Read_Flag !== 4'b0010) begin testsFailed++; $display("FAIL b2b_flag got=%b exp=%b", Read_Flag, 4'b0010); end
        step;
        testsRun++; if (Done !== 1'b0) begin testsFailed++; $display("FAIL b2b_done_clear got=%b exp=0", Done); end
        drive(OP_SUB, OPSEL_A_T1, 1'b1, 1'b1, 16'h0010, 16'h0000);
        step;
        Enable = 1'b0;
        testsRun++; if (Read_T1 !== 16'hFFE0) begin testsFailed++; $display("FAIL sub_borrow_t1 got=%h exp=%h", Read_T1, 16'hFFE0); end
        testsRun++; if (Read_Flag !== 4'b0100) begin testsFailed++; $display("FAIL sub_borrow_flag got=%b exp=%b", Read_Flag, 4'b0100); end
        step;
    endtask

    initial begin
        ResetN        = 1'b0;
        Enable        = 1'b0;
        ExtOpCode     = OP_ADD;
        OperandSelect = OPSEL_A_B;
        UpdateResult  = 1'b0;
        UpdateFlag    = 1'b0;
        Bus_A         = '0;
        Bus_B         = '0;
        test_reset;
        test_add_overflow;
        test_cmp;
        test_shl_busy;
        test_shr;
        test_logic;
        test_reset_mid_shift;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
